// File: rtl/serial_add_pkg.sv
// Shared types and limits for the bit-serial adder controller.
package serial_add_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sa_state_t;

  localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Command/result bundle between a requester and the bit-serial adder controller.
interface serial_add_ctrl_if #(
  parameter int WIDTH = 8
);

  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b,
    output ready, busy, done, sum, cout
  );

endinterface

// File: rtl/halfadder.sv
// One-bit half adder cell.
module halfadder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/serial_fa.sv
// One-bit full adder composed of two half adders and an OR on their carries.
module serial_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic w_s1;
  logic w_c1;
  logic w_c2;

  halfadder u_ha0 (.a(a),    .b(b),   .sum(w_s1), .carry(w_c1));
  halfadder u_ha1 (.a(w_s1), .b(cin), .sum(sum),  .carry(w_c2));

  assign cout = w_c1 | w_c2;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder: latches operands on start, adds one bit per cycle
// LSB-first through a shared full adder, then pulses done for one cycle.
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  serial_add_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  if (WIDTH < 1 || WIDTH > MAX_WIDTH) begin : g_bad_width
    $error("serial_add_ctrl: WIDTH %0d outside 1..%0d", WIDTH, MAX_WIDTH);
  end

  sa_state_t        r_state;
  sa_state_t        w_state_next;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_c;
  logic             r_cout;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;
  logic             w_c_next;
  logic             w_last;
  logic [WIDTH-1:0] w_acc_next;

  serial_fa u_fa (
    .a   (r_sa[0]),
    .b   (r_sb[0]),
    .cin (r_c),
    .sum (w_s),
    .cout(w_c_next)
  );

  assign w_last     = (r_cnt == CNT_W'(WIDTH - 1));
  // New sum bit enters at the MSB so the LSB-first result ends up aligned.
  assign w_acc_next = (r_acc >> 1) | (WIDTH'(w_s) << (WIDTH - 1));

  // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    w_state_next = r_state;
    bus.ready    = 1'b0;
    bus.busy     = 1'b0;
    bus.done     = 1'b0;
    unique case (r_state)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) w_state_next = RUN;
      end
      RUN: begin
        bus.busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        bus.done     = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_sa    <= '0;
      r_sb    <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_c     <= 1'b0;
      r_cout  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_next;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sa  <= bus.a;
            r_sb  <= bus.b;
            r_c   <= 1'b0;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_sa  <= r_sa >> 1;
          r_sb  <= r_sb >> 1;
          r_acc <= w_acc_next;
          r_c   <= w_c_next;
          r_cnt <= r_cnt + CNT_W'(1);
          // Visible result only updates as the final bit lands.
          if (w_last) begin
            r_sum  <= w_acc_next;
            r_cout <= w_c_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench: WIDTH=8 and WIDTH=1 instances against a cycle-count model.
module tb_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(8)) if8 ();
  serial_add_ctrl_if #(.WIDTH(1)) if1 ();

  serial_add_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));
  serial_add_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave));

  // Index 0 drives the WIDTH=8 instance, index 1 the WIDTH=1 instance.
  logic        drv_start [2];
  logic [31:0] drv_a     [2];
  logic [31:0] drv_b     [2];
  logic        rdy [2];
  logic        bsy [2];
  logic        dn  [2];
  logic [31:0] sm  [2];
  logic        co  [2];

  assign if8.start = drv_start[0];
  assign if8.a     = drv_a[0][7:0];
  assign if8.b     = drv_b[0][7:0];
  assign if1.start = drv_start[1];
  assign if1.a     = drv_a[1][0:0];
  assign if1.b     = drv_b[1][0:0];

  assign rdy[0] = if8.ready;  assign rdy[1] = if1.ready;
  assign bsy[0] = if8.busy;   assign bsy[1] = if1.busy;
  assign dn[0]  = if8.done;   assign dn[1]  = if1.done;
  assign sm[0]  = {24'b0, if8.sum};
  assign sm[1]  = {31'b0, if1.sum};
  assign co[0]  = if8.cout;   assign co[1]  = if1.cout;

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int wid(input int s);
    return (s == 0) ? 8 : 1;
  endfunction

  function automatic logic [32:0] msk(input int s);
    return (33'd1 << wid(s)) - 33'd1;
  endfunction

  // Model: m_t = cycles since the accepting edge (-1 when idle); the result
  // (a+b with carry) appears when m_t reaches WIDTH and is held afterwards.
  int          m_t   [2];
  logic [32:0] m_res [2];
  logic [32:0] m_pend[2];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int s = 0; s < 2; s++) begin
      if (rst) begin
        m_t[s]   <= -1;
        m_res[s] <= '0;
      end else if (m_t[s] < 0) begin
        if (drv_start[s]) begin
          m_t[s]    <= 0;
          m_pend[s] <= ({1'b0, drv_a[s]} & msk(s)) + ({1'b0, drv_b[s]} & msk(s));
        end
      end else if (m_t[s] == wid(s)) begin
        m_t[s] <= -1;
      end else begin
        m_t[s] <= m_t[s] + 1;
        if (m_t[s] + 1 == wid(s)) m_res[s] <= m_pend[s];
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int s = 0; s < 2; s++) begin
        check($sformatf("ready_w%0d", wid(s)), rdy[s], m_t[s] < 0);
        check($sformatf("busy_w%0d", wid(s)), bsy[s], (m_t[s] >= 0) && (m_t[s] < wid(s)));
        check($sformatf("done_w%0d", wid(s)), dn[s], m_t[s] == wid(s));
        if (m_t[s] < 0 || m_t[s] == wid(s)) begin
          check($sformatf("sum_w%0d", wid(s)), sm[s], m_res[s] & msk(s));
          check($sformatf("cout_w%0d", wid(s)), co[s], m_res[s][wid(s)]);
        end
      end
    end
  end

  task automatic wait_ready(input int s);
    int k = 0;
    while (!rdy[s] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!rdy[s]) check("ready_wait", rdy[s], 1);
  endtask

  // Called at a negedge; returns at the negedge where done is seen.
  task automatic do_add(input int s, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int bcnt);
    wait_ready(s);
    drv_start[s] = 1'b1;
    drv_a[s]     = a;
    drv_b[s]     = b;
    @(negedge clk);
    drv_start[s] = 1'b0;
    drv_a[s]     = $urandom;
    drv_b[s]     = $urandom;
    bcnt = int'(bsy[s]);
    lat  = -1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (dn[s]) begin
        lat = i;
        break;
      end
      bcnt += int'(bsy[s]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, bcnt, d;
    int acc_q[$];
    logic [31:0] ra, rb;
    logic [31:0] vec8[3][4] = '{'{255, 1, 0, 1}, '{255, 255, 254, 1}, '{0, 0, 0, 0}};
    logic [31:0] vec1[4][4] = '{'{0, 0, 0, 0}, '{0, 1, 1, 0}, '{1, 0, 1, 0}, '{1, 1, 0, 1}};

    rst = 1'b1;
    for (int s = 0; s < 2; s++) begin
      drv_start[s] = 1'b0;
      drv_a[s]     = '0;
      drv_b[s]     = '0;
    end
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_ready", rdy[0], 1);
    check("rst_busy",  bsy[0], 0);
    check("rst_done",  dn[0],  0);
    check("rst_sum",   sm[0],  0);
    check("rst_cout",  co[0],  0);
    rst = 1'b0;
    @(negedge clk);

    // 3 + 5
    do_add(0, 3, 5, lat, bcnt);
    check("lat_3p5",   lat,  8);
    check("busy_3p5",  bcnt, 8);
    check("sum_3p5",   sm[0], 8);
    check("cout_3p5",  co[0], 0);
    check("model_3p5", m_res[0], 33'd8);

    // Carry boundary cases
    for (int i = 0; i < 3; i++) begin
      do_add(0, vec8[i][0], vec8[i][1], lat, bcnt);
      check($sformatf("lat_v%0d", i),  lat,   8);
      check($sformatf("sum_v%0d", i),  sm[0], vec8[i][2]);
      check($sformatf("cout_v%0d", i), co[0], vec8[i][3]);
    end

    // start held high with operands changing every cycle
    wait_ready(0);
    drv_start[0] = 1'b1;
    for (int i = 0; i < 45; i++) begin
      drv_a[0] = $urandom;
      drv_b[0] = $urandom;
      if (rdy[0]) acc_q.push_back(cyc);
      @(negedge clk);
    end
    drv_start[0] = 1'b0;
    check("cont_accepts", acc_q.size(), 5);
    for (int i = 1; i < acc_q.size(); i++)
      check($sformatf("cont_spacing%0d", i), acc_q[i] - acc_q[i-1], 10);

    // Reset four cycles into 100 + 27
    wait_ready(0);
    drv_start[0] = 1'b1;
    drv_a[0]     = 100;
    drv_b[0]     = 27;
    @(negedge clk);
    drv_start[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready", rdy[0], 1);
    check("abort_busy",  bsy[0], 0);
    check("abort_sum",   sm[0],  0);
    check("abort_cout",  co[0],  0);
    rst = 1'b0;
    d = 0;
    repeat (12) begin
      @(negedge clk);
      d += int'(dn[0]);
    end
    check("abort_no_done", d, 0);
    do_add(0, 100, 27, lat, bcnt);
    check("lat_127",  lat,   8);
    check("sum_127",  sm[0], 127);
    check("cout_127", co[0], 0);

    // Reset and start together from IDLE
    rst          = 1'b1;
    drv_start[0] = 1'b1;
    drv_a[0]     = 9;
    drv_b[0]     = 9;
    @(negedge clk);
    check("rs_ready", rdy[0], 1);
    check("rs_busy",  bsy[0], 0);
    rst          = 1'b0;
    drv_start[0] = 1'b0;
    d = 0;
    repeat (12) begin
      @(negedge clk);
      d += int'(dn[0]) + int'(bsy[0]);
    end
    check("rs_no_activity", d, 0);

    // Random operands with random idle gaps
    for (int i = 0; i < 16; i++) begin
      ra = $urandom_range(0, 255);
      rb = $urandom_range(0, 255);
      do_add(0, ra, rb, lat, bcnt);
      check("rnd_lat", lat, 8);
      check("rnd_sum", {co[0], sm[0][7:0]}, ra + rb);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // WIDTH=1 truth table
    for (int i = 0; i < 4; i++) begin
      do_add(1, vec1[i][0], vec1[i][1], lat, bcnt);
      check($sformatf("w1_lat%0d", i),  lat,   1);
      check($sformatf("w1_busy%0d", i), bcnt,  1);
      check($sformatf("w1_sum%0d", i),  sm[1], vec1[i][2]);
      check($sformatf("w1_cout%0d", i), co[1], vec1[i][3]);
    end

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
